// File: rtl/axi3_rd_burst_slave_if.sv
// AXI3 read address/data channels plus the 1-cycle-latency memory port of axi3_rd_burst_slave.
// slave = the burst slave side, master = interconnect/memory side (used by the bench).
interface axi3_rd_burst_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready, mem_rdata, mem_err,
    output arready, rid, rdata, rresp, rlast, rvalid, mem_req, mem_addr
  );
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready, mem_rdata, mem_err,
    input  arready, rid, rdata, rresp, rlast, rvalid, mem_req, mem_addr
  );
endinterface

// File: rtl/axi3_rd_burst_slave.sv
// AXI3 read burst slave: expands one AR burst into single-word memory reads, returns R beats via a 2-deep FIFO.
// Optional AXI3_RD_ERRCHK_EN: illegal bursts are answered with SLVERR beats and never touch memory.
module axi3_rd_burst_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input logic                  aclk,
  input logic                  areset,
  axi3_rd_burst_slave_if.slave bus
);
  localparam logic [1:0] XBURST_FIXED    = 2'b00;
  localparam logic [1:0] XBURST_INCR     = 2'b01;
  localparam logic [1:0] XBURST_WRAP     = 2'b10;
  localparam logic [1:0] XBURST_RESERVED = 2'b11;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_SLVERR     = 2'b10;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q, nxt_addr, inc, wmask;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q, illegal;
  logic [4:0]        issued_q, pushed_q;
  logic              inflight_q;
  logic              arready_c, mem_req_c, err_push, push, pop, ar_hs;

  logic [DATA_W-1:0] f_data_q [2];
  logic [1:0]        f_resp_q [2];
  logic              f_last_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        fifo_cnt_q;

`ifdef AXI3_RD_ERRCHK_EN
  localparam int LANE_LOG = $clog2(DATA_W/8);
  assign illegal = (bus.arburst == XBURST_RESERVED) ||
                   ((bus.arburst == XBURST_WRAP) && !(bus.arlen inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
                   (int'(bus.arsize) > LANE_LOG);
`else
  assign illegal = 1'b0;
`endif

  assign ar_hs = bus.arvalid & arready_c;
  assign pop   = (fifo_cnt_q != 2'd0) & bus.rready;
  assign push  = inflight_q | err_push;

  always_comb begin
    state_d   = state_q;
    arready_c = 1'b0;
    mem_req_c = 1'b0;
    err_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        arready_c = ~areset;
        if (bus.arvalid && !areset) state_d = S_BURST;
      end
      S_BURST: begin
        // inflight counts the read whose data lands next cycle, so FIFO can never overflow
        if (issued_q <= {1'b0, len_q}) begin
          if (err_q) err_push  = (fifo_cnt_q != 2'd2);
          else       mem_req_c = (fifo_cnt_q + {1'b0, inflight_q}) < 2'd2;
        end
        if (pop && f_last_q[rd_ptr_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inc      = ADDR_W'(1) << size_q;
    wmask    = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    nxt_addr = addr_q;
    case (burst_q)
      XBURST_INCR:                   nxt_addr = (addr_q & ~(inc - ADDR_W'(1))) + inc;
      XBURST_WRAP:                   nxt_addr = (addr_q & ~wmask) | ((addr_q + inc) & wmask);
      XBURST_FIXED, XBURST_RESERVED: nxt_addr = addr_q;
      default:                       nxt_addr = addr_q;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      issued_q   <= '0;
      pushed_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        f_data_q[i] <= '0;
        f_resp_q[i] <= '0;
        f_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_req_c;
      if (mem_req_c || err_push) begin
        issued_q <= issued_q + 5'd1;
        if (mem_req_c) addr_q <= nxt_addr;
      end
      if (push) begin
        f_data_q[wr_ptr_q] <= err_q ? '0 : bus.mem_rdata;
        f_resp_q[wr_ptr_q] <= (err_q || bus.mem_err) ? RESP_SLVERR : RESP_OKAY;
        f_last_q[wr_ptr_q] <= (pushed_q == {1'b0, len_q});
        wr_ptr_q           <= ~wr_ptr_q;
        pushed_q           <= pushed_q + 5'd1;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      if (ar_hs) begin
        id_q     <= bus.arid;
        addr_q   <= bus.araddr;
        len_q    <= bus.arlen;
        size_q   <= bus.arsize;
        burst_q  <= bus.arburst;
        err_q    <= illegal;
        issued_q <= '0;
        pushed_q <= '0;
      end
    end
  end

  assign bus.arready  = arready_c;
  assign bus.mem_req  = mem_req_c;
  assign bus.mem_addr = addr_q;
  assign bus.rvalid   = (fifo_cnt_q != 2'd0);
  assign bus.rdata    = f_data_q[rd_ptr_q];
  assign bus.rresp    = f_resp_q[rd_ptr_q];
  assign bus.rlast    = f_last_q[rd_ptr_q];
  assign bus.rid      = id_q;
endmodule

// File: tb/tb_axi3_rd_burst_slave.sv
// Directed bench for axi3_rd_burst_slave: table of bursts with hand-computed addresses,
// plus sequences for backpressure, reset mid-burst and the reserved burst type.
module tb_axi3_rd_burst_slave;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi3_rd_burst_slave_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();
  axi3_rd_burst_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .aclk(clk), .areset(rst), .bus(bus.slave)
  );

  logic [31:0] err_addr = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_addr ^ K;
    bus.mem_err   <= bus.mem_req && (bus.mem_addr == err_addr);
  end

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    int               err_beat;
    logic [3:0][31:0] exp_a;
  } vec_t;

  int checks = 0, failures = 0;
  logic [31:0] got_addr[$], got_data[$], ea[$], ed[$];
  logic [1:0]  got_resp[$], er[$];
  bit          got_last[$];
  logic [3:0]  got_id[$];
  int          max_out, first_req_cyc;
  bit          timed_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall);
    int n, cyc, outst, stall_left;
    bit seen, done;
    got_addr.delete(); got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
    max_out = 0; first_req_cyc = -1; timed_out = 0;
    @(negedge clk);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.arvalid = 1'b0;
    cyc = 0; outst = 0; seen = 0; done = 0; stall_left = stall;
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
      if (bus.rvalid) seen = 1;
      bus.rready = !(seen && stall_left > 0);
      if (seen && stall_left > 0) stall_left--;
      if (bus.mem_req) begin
        got_addr.push_back(bus.mem_addr);
        if (first_req_cyc < 0) first_req_cyc = cyc;
        outst++;
      end
      if (outst > max_out) max_out = outst;
      if (bus.rvalid && bus.rready) begin
        got_data.push_back(bus.rdata); got_resp.push_back(bus.rresp);
        got_last.push_back(bus.rlast); got_id.push_back(bus.rid);
        outst--;
        if (bus.rlast) done = 1;
      end
    end
    timed_out = !done;
    bus.rready = 1'b1;
  endtask

  task automatic check_results(input string tag, input logic [3:0] id);
    check({tag, " timeout"}, 64'(timed_out), 64'd0);
    check({tag, " nreq"}, 64'(got_addr.size()), 64'(ea.size()));
    if (ea.size() > 0) check({tag, " first_req_cycle"}, 64'(first_req_cyc), 64'd1);
    foreach (ea[i])
      if (i < got_addr.size()) check($sformatf("%s addr%0d", tag, i), 64'(got_addr[i]), 64'(ea[i]));
    check({tag, " nbeats"}, 64'(got_data.size()), 64'(ed.size()));
    foreach (ed[i])
      if (i < got_data.size()) begin
        check($sformatf("%s data%0d", tag, i), 64'(got_data[i]), 64'(ed[i]));
        check($sformatf("%s resp%0d", tag, i), 64'(got_resp[i]), 64'(er[i]));
        check($sformatf("%s last%0d", tag, i), 64'(got_last[i]), 64'(i == ed.size() - 1));
        check($sformatf("%s id%0d", tag, i), 64'(got_id[i]), 64'(id));
      end
    check({tag, " outstanding<=2"}, 64'(max_out <= 2), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " arready"},  64'(bus.arready),  64'd0);
    check({tag, " rvalid"},   64'(bus.rvalid),   64'd0);
    check({tag, " rlast"},    64'(bus.rlast),    64'd0);
    check({tag, " rresp"},    64'(bus.rresp),    64'd0);
    check({tag, " rid"},      64'(bus.rid),      64'd0);
    check({tag, " rdata"},    64'(bus.rdata),    64'd0);
    check({tag, " mem_req"},  64'(bus.mem_req),  64'd0);
    check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{id: 4'h3, addr: 32'h100, len: 4'd3, size: 3'd2, burst: 2'b01, err_beat: -1,
                exp_a: {32'h10C, 32'h108, 32'h104, 32'h100}};
    vecs[1] = '{id: 4'h5, addr: 32'h108, len: 4'd3, size: 3'd2, burst: 2'b10, err_beat: -1,
                exp_a: {32'h104, 32'h100, 32'h10C, 32'h108}};
    vecs[2] = '{id: 4'h1, addr: 32'h40, len: 4'd2, size: 3'd2, burst: 2'b00, err_beat: -1,
                exp_a: {32'h0, 32'h40, 32'h40, 32'h40}};
    vecs[3] = '{id: 4'h9, addr: 32'h100, len: 4'd3, size: 3'd2, burst: 2'b01, err_beat: 1,
                exp_a: {32'h10C, 32'h108, 32'h104, 32'h100}};
    vecs[4] = '{id: 4'h2, addr: 32'h103, len: 4'd2, size: 3'd2, burst: 2'b01, err_beat: -1,
                exp_a: {32'h0, 32'h108, 32'h104, 32'h103}};
    vecs[5] = '{id: 4'hE, addr: 32'hFFFF_FFF8, len: 4'd2, size: 3'd2, burst: 2'b01, err_beat: -1,
                exp_a: {32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8}};
    vecs[6] = '{id: 4'h6, addr: 32'h22, len: 4'd1, size: 3'd1, burst: 2'b10, err_beat: -1,
                exp_a: {32'h0, 32'h0, 32'h20, 32'h22}};
    vecs[7] = '{id: 4'hF, addr: 32'h7, len: 4'd0, size: 3'd0, burst: 2'b01, err_beat: -1,
                exp_a: {32'h0, 32'h0, 32'h0, 32'h7}};

    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b1;

    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle arready", 64'(bus.arready), 64'd1);

    for (int v = 0; v < 8; v++) begin
      err_addr = (vecs[v].err_beat >= 0) ? vecs[v].exp_a[vecs[v].err_beat] : 32'hDEAD_BEEF;
      ea.delete(); ed.delete(); er.delete();
      for (int i = 0; i <= int'(vecs[v].len); i++) begin
        ea.push_back(vecs[v].exp_a[i]);
        ed.push_back(vecs[v].exp_a[i] ^ K);
        er.push_back((i == vecs[v].err_beat) ? 2'b10 : 2'b00);
      end
      run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0);
      check_results($sformatf("v%0d", v), vecs[v].id);
    end
    err_addr = 32'hDEAD_BEEF;

    // 16-beat INCR with R backpressure right after the first beat shows up
    ea.delete(); ed.delete(); er.delete();
    for (int i = 0; i < 16; i++) begin
      ea.push_back(32'h200 + 32'(4 * i)); ed.push_back((32'h200 + 32'(4 * i)) ^ K); er.push_back(2'b00);
    end
    run_burst(4'hA, 32'h200, 4'd15, 3'd2, 2'b01, 6);
    check_results("stall16", 4'hA);

    // reserved burst type
    ea.delete(); ed.delete(); er.delete();
`ifdef AXI3_RD_ERRCHK_EN
    for (int i = 0; i < 2; i++) begin ed.push_back(32'h0); er.push_back(2'b10); end
`else
    for (int i = 0; i < 2; i++) begin ea.push_back(32'h80); ed.push_back(32'h80 ^ K); er.push_back(2'b00); end
`endif
    run_burst(4'h4, 32'h80, 4'd1, 3'd2, 2'b11, 0);
    check_results("reserved", 4'h4);

    // reset pulsed mid-burst with data parked in the FIFO
    @(negedge clk);
    bus.arid = 4'h7; bus.araddr = 32'h300; bus.arlen = 4'd3; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("midburst rvalid", 64'(bus.rvalid), 64'd1);
    rst = 1'b1; #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset hold");
    rst = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    check("post-reset arready", 64'(bus.arready), 64'd1);
    check("post-reset rvalid", 64'(bus.rvalid), 64'd0);
    ea.delete(); ed.delete(); er.delete();
    for (int i = 0; i < 4; i++) begin
      ea.push_back(vecs[0].exp_a[i]); ed.push_back(vecs[0].exp_a[i] ^ K); er.push_back(2'b00);
    end
    run_burst(vecs[0].id, vecs[0].addr, vecs[0].len, vecs[0].size, vecs[0].burst, 0);
    check_results("after_reset", vecs[0].id);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
